apb_mem_slave: RTL
==================

# apb_mem_slave

APB slave front-end that sits directly upstream of the byte-lane APB memory. It accepts APB3/APB4 transfers from the bridge's downstream APB port and converts each one into a single memory-bus operation: a one-cycle write strobe with byte enables, or a read enable with captured read data. It also inserts a programmable number of wait states and flags decode errors on `pslverr`.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: APB address width.
- `DATA_WIDTH`, 32: APB data width. Must equal `MEM_WIDTH*MEM_DEPTH`.
- `MEM_WIDTH`, 8: bits per memory lane.
- `MEM_DEPTH`, 4: number of byte lanes. Equals the `pstrb` width.
- `MEM_AW`, 8: memory word-address width (`MEM_SIZE` = 2^`MEM_AW`).
- `WAIT_STATES`, 0: extra access-phase cycles, range 0..15.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous assert, active-high.
- `psel`, `penable`, `pwrite`  in  1 each: APB control.
- `paddr`  in  `ADDR_WIDTH`: byte address.
- `pwdata`  in  `DATA_WIDTH`: write data.
- `pstrb`  in  `MEM_DEPTH`: write byte strobes.
- `prdata`  out  `DATA_WIDTH`: registered read data.
- `pready`  out  1: transfer complete.
- `pslverr`  out  1: error response, valid only with `pready`.
- `mem_wr`  out  1: memory write strobe.
- `mem_rd`  out  1: memory read enable.
- `mem_be`  out  `MEM_DEPTH`: lane enables.
- `mem_address`  out  `MEM_AW`: word address.
- `mem_data_in`  out  `DATA_WIDTH`: data to memory.
- `mem_data_out`  in  `DATA_WIDTH`: combinational read data from memory.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- **IDLE**
  - Trigger: `psel=1` and `penable=0` (setup phase).
  - Latch `pwrite`, `pwdata` and `pstrb`.
  - Latch `mem_address` = `paddr[MEM_AW+1:2]`.
  - Latch `err` = (`paddr[1:0]`≠0) OR (`paddr[ADDR_WIDTH-1:MEM_AW+2]`≠0).
  - Load `cnt` with `WAIT_STATES`, then go to WAIT.
- **WAIT**
  - `pready=0`.
  - `mem_rd=1` when the transfer is a read and `err=0`.
  - If `cnt`==0, go to RESP. Otherwise decrement `cnt`.
  - On the WAIT→RESP edge:
    - `prdata` ← `mem_data_out` for a valid read; 0 for a write or on error.
    - `pslverr` ← `err`.
  - If `psel` drops while in WAIT: abort, go to IDLE, no memory write, no `pready`.
- **RESP**
  - `pready=1` for exactly one cycle.
  - For a valid write with `pstrb`≠0, `mem_wr=1` in this cycle. The memory commits on the same edge that completes the APB transfer.
  - Next state is always IDLE.
- `mem_be`
  - Write: latched `pstrb`.
  - Read: 0.
  - Write with `pstrb`=0: no `mem_wr`, `pslverr=0`, normal completion.
- `mem_data_in` = latched `pwdata`, held stable from WAIT through RESP.
- Setup phase seen in WAIT or RESP is a protocol violation: ignored.
- Reset at any point returns to IDLE. A pending write is dropped.

## Timing
- Reset values: `prdata`=0, `pready`=0, `pslverr`=0, `mem_wr`=0, `mem_rd`=0, `mem_be`=0, `mem_address`=0, `mem_data_in`=0, `cnt`=0, state IDLE.
- All outputs are registered or decoded from state only. There are no combinational paths from APB inputs to APB outputs.
- Cycle sequence with setup in cycle T0:
  - T1..T1+`WAIT_STATES`: WAIT.
  - T2+`WAIT_STATES`: RESP, `pready=1`.
- With `WAIT_STATES`=0, every transfer takes 3 cycles including setup.
- Back-to-back transfers: the next setup phase may arrive in the cycle after RESP. Throughput is one transfer per `WAIT_STATES`+3 cycles.
- `mem_rd` rises at T1 and falls on the cycle RESP begins.
- `prdata` is stable during RESP and holds its value until the next read completes.

## Test plan
- Zero wait states:
  - Stimulus: write 0xDEADBEEF to 0x10 with `pstrb`=0xF, then read 0x10.
  - Response: `mem_wr` high for 1 cycle at address 4; read gives `prdata`=0xDEADBEEF, `pready` 2 cycles after setup, `pslverr`=0.
- Byte strobes:
  - Stimulus: write 0x11223344 to 0x20 with `pstrb`=0x5 over prior content 0xAAAAAAAA.
  - Response: readback = 0xAA22AA44. A write with `pstrb`=0 leaves memory unchanged and `pslverr`=0.
- Decode error:
  - Stimulus: write to 0x400 (out of range), and a read from 0x13 (unaligned).
  - Response: `pslverr`=1 with `pready`, `mem_wr` never asserted, `prdata`=0.
- Wait states (`WAIT_STATES`=3):
  - Stimulus: a read.
  - Response: `pready` asserts exactly 5 cycles after the setup cycle; `mem_rd` is high for 4 cycles.
- Abort:
  - Stimulus: `psel` deasserted in the second WAIT cycle of a write.
  - Response: no `mem_wr`, no `pready`; FSM returns to IDLE and accepts the next setup.
- Reset mid-operation:
  - Stimulus: assert `rst` during WAIT of a write.
  - Response: all outputs go to their reset values immediately, memory is unmodified, and a subsequent read returns the old data.

Source files
------------

// File: rtl/apb_mem_slave.sv
// APB3/APB4 slave front-end for a byte-lane memory: turns each APB transfer into
// one memory read or strobed write, with programmable wait states and decode errors.
module apb_mem_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_WIDTH   = 8,
  parameter int MEM_DEPTH   = 4,
  parameter int MEM_AW      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [MEM_DEPTH-1:0]  pstrb,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  mem_wr,
  output logic                  mem_rd,
  output logic [MEM_DEPTH-1:0]  mem_be,
  output logic [MEM_AW-1:0]     mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam int            LINE_BITS = MEM_WIDTH * MEM_DEPTH;
  localparam logic [3:0]    WS_LOAD   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   wr_q, wr_d;
  logic                   err_q, err_d;
  logic [MEM_DEPTH-1:0]   mem_be_q, mem_be_d;
  logic [MEM_AW-1:0]      mem_address_q, mem_address_d;
  logic [LINE_BITS-1:0]   mem_data_in_q, mem_data_in_d;
  logic [DATA_WIDTH-1:0]  prdata_q, prdata_d;
  logic                   pslverr_q, pslverr_d;
  logic                   setup;
  logic                   decode_err;

  assign setup      = psel && !penable;
  assign decode_err = (paddr[1:0] != 2'b00) || (|paddr[ADDR_WIDTH-1:MEM_AW+2]);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_d          = wr_q;
    err_d         = err_q;
    mem_be_d      = mem_be_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    prdata_d      = prdata_q;
    pslverr_d     = pslverr_q;

    case (state_q)
      S_IDLE: begin
        if (setup) begin
          wr_d          = pwrite;
          err_d         = decode_err;
          mem_be_d      = pwrite ? pstrb : '0;
          mem_address_d = paddr[MEM_AW+1:2];
          mem_data_in_d = pwdata;
          cnt_d         = WS_LOAD;
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        // A dropped psel abandons the transfer before anything reaches memory.
        if (!psel) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          prdata_d  = (!wr_q && !err_q) ? mem_data_out : '0;
          pslverr_d = err_q;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      wr_q          <= 1'b0;
      err_q         <= 1'b0;
      mem_be_q      <= '0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      prdata_q      <= '0;
      pslverr_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_q          <= wr_d;
      err_q         <= err_d;
      mem_be_q      <= mem_be_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      prdata_q      <= prdata_d;
      pslverr_q     <= pslverr_d;
    end
  end

  // Memory strobes decode from state and latched transfer attributes only.
  assign pready      = (state_q == S_RESP);
  assign mem_rd      = (state_q == S_WAIT) && !wr_q && !err_q;
  assign mem_wr      = (state_q == S_RESP) && wr_q && !err_q && (|mem_be_q);
  assign mem_be      = mem_be_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
  assign prdata      = prdata_q;
  assign pslverr     = pslverr_q;

endmodule
